// File: rtl/bnn_pkg.sv
// Shared types and default sizing for the BNN output stage.
// Scores are unsigned popcounts; a class index fits in four bits.
package bnn_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int SCORE_WIDTH = 8;

    typedef logic [SCORE_WIDTH-1:0] score_t;
    typedef logic [3:0]             class_idx_t;

    typedef enum logic {
        S_ACCUM,
        S_DONE
    } argmax_state_e;

endpackage

// File: rtl/bnn_argmax_if.sv
// Score stream from the BNN output layer: one class score per accepted beat.
// The producer is the master; the argmax stage is the slave.
interface bnn_argmax_if #(
    parameter int SCORE_WIDTH = bnn_pkg::SCORE_WIDTH
);
    logic                   score_valid;
    logic [SCORE_WIDTH-1:0] score_in;
    logic                   score_ready;

    modport master (
        output score_valid,
        output score_in,
        input  score_ready
    );

    modport slave (
        input  score_valid,
        input  score_in,
        output score_ready
    );
endinterface

// File: rtl/bnn_argmax.sv
// Streaming argmax over one frame of per-class scores.
// Emits the winning class index as a one-cycle pulse after the last score.
module bnn_argmax
    import bnn_pkg::*;
#(
    parameter int NUM_CLASSES = bnn_pkg::NUM_CLASSES,
    parameter int SCORE_WIDTH = bnn_pkg::SCORE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    bnn_argmax_if.slave            score,
    output logic                   result_ready,
    output class_idx_t             result_out,
    output logic [SCORE_WIDTH-1:0] result_score,
    output logic                   busy
);

    localparam class_idx_t LAST_IDX = class_idx_t'(NUM_CLASSES - 1);

    if (NUM_CLASSES < 2 || NUM_CLASSES > 16) begin : g_bad_num_classes
        $error("bnn_argmax: NUM_CLASSES must be in 2..16");
    end

    argmax_state_e          state_q;
    argmax_state_e          state_d;
    class_idx_t             idx_q;
    class_idx_t             best_idx_q;
    logic [SCORE_WIDTH-1:0] best_score_q;
    logic                   take;
    logic                   is_last;
    logic                   better;

    // A clear in the same cycle as an accept drops the score entirely.
    assign score.score_ready = (state_q == S_ACCUM) && !rst;
    assign take              = score.score_valid && score.score_ready && !clear;
    assign is_last           = (idx_q == LAST_IDX);

    // Strictly greater keeps the lowest index on ties; index 0 always loads.
    assign better = (idx_q == '0) || (score.score_in > best_score_q);

    assign result_ready = (state_q == S_DONE);
    assign busy         = (state_q == S_DONE) || (idx_q != '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_ACCUM: if (take && is_last) state_d = S_DONE;
            S_DONE:  state_d = S_ACCUM;
            default: state_d = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_ACCUM;
            idx_q        <= '0;
            result_out   <= '0;
            result_score <= '0;
        end else begin
            state_q <= state_d;
            if (clear || state_q == S_DONE) begin
                idx_q <= '0;
            end else if (take) begin
                idx_q <= idx_q + 4'd1;
            end
            // Results are captured with the final score folded in, then held.
            if (take && is_last) begin
                result_out   <= better ? idx_q : best_idx_q;
                result_score <= better ? score.score_in : best_score_q;
            end
        end
    end

    // Running best needs no reset: the first accept of every frame overwrites it.
    always_ff @(posedge clk) begin
        if (take && better) begin
            best_idx_q   <= idx_q;
            best_score_q <= score.score_in;
        end
    end

endmodule

// File: tb/tb_bnn_argmax.sv
// Randomized self-checking bench for bnn_argmax against a max/first-index model.
module tb_bnn_argmax;

    localparam int NC = 10;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          result_ready;
    logic [3:0]    result_out;
    logic [SW-1:0] result_score;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bnn_argmax_if #(.SCORE_WIDTH(SW)) sif ();

    bnn_argmax #(.NUM_CLASSES(NC), .SCORE_WIDTH(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .score        (sif),
        .result_ready (result_ready),
        .result_out   (result_out),
        .result_score (result_score),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: every result_ready cycle with its outputs.
    int p_cyc[$];
    int p_out[$];
    int p_score[$];
    always @(negedge clk) begin
        if (result_ready === 1'b1) begin
            p_cyc.push_back(cyc);
            p_out.push_back(int'(result_out));
            p_score.push_back(int'(result_score));
        end
    end

    int   frame[$];
    int   last_acc;
    int   ready_low;
    logic chk_busy = 1'b0;

    // Winner = highest value, lowest index among equals.
    function automatic void ref_argmax(input int f[$], output int widx, output int wsc);
        int mx[$];
        int ix[$];
        mx   = f.max();
        ix   = f.find_first_index(x) with (x == mx[0]);
        wsc  = mx[0];
        widx = ix[0];
    endfunction

    function automatic void clear_pulses();
        p_cyc.delete();
        p_out.delete();
        p_score.delete();
    endfunction

    task automatic drive_scores(input int gap_pct);
        int   i = 0;
        int   guard = 0;
        logic acc;
        ready_low = 0;
        while (i < frame.size() && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (chk_busy && i > 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_mid_frame: busy=%b required 1 (cycle %0d)", busy, cyc);
                end
            end
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                sif.score_valid = 1'b0;
            end else begin
                sif.score_valid = 1'b1;
                sif.score_in    = SW'(frame[i]);
            end
            if (sif.score_ready !== 1'b1) ready_low++;
            acc = sif.score_valid && sif.score_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                i++;
                last_acc = cyc;
            end
        end
        checks++;
        if (i < frame.size()) begin
            errors++;
            $display("FAIL drive_timeout: accepted %0d required %0d", i, frame.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear = 1'b0;
        sif.score_valid = 1'b0;
        sif.score_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sif.score_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", sif.score_ready); end
        checks++;
        if ({result_ready, busy} !== 2'b00) begin errors++; $display("FAIL reset_flags: ready/busy=%b required 00", {result_ready, busy}); end
        checks++;
        if (result_out !== 4'd0 || result_score !== '0) begin
            errors++; $display("FAIL reset_result: out=%0d score=%0d required 0 0", result_out, result_score);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (sif.score_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b required 1", sif.score_ready); end
    endtask

    task automatic test_single_frame();
        int eo, es;
        clear_pulses();
        frame = '{3, 7, 2, 9, 1, 0, 9, 4, 5, 6};
        ref_argmax(frame, eo, es);
        drive_scores(0);
        @(negedge clk);
        sif.score_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (p_cyc.size() != 1) begin errors++; $display("FAIL single_pulse_count: got %0d required 1", p_cyc.size()); end
        else begin
            checks++;
            if (p_cyc[0] != last_acc) begin errors++; $display("FAIL single_latency: pulse cycle %0d required %0d", p_cyc[0], last_acc); end
            checks++;
            if (p_out[0] != eo || p_score[0] != es) begin
                errors++; $display("FAIL single_result: out=%0d score=%0d required %0d %0d", p_out[0], p_score[0], eo, es);
            end
        end
        checks++;
        if (int'(result_out) != eo || int'(result_score) != es) begin
            errors++; $display("FAIL single_hold: out=%0d score=%0d required %0d %0d", result_out, result_score, eo, es);
        end
    endtask

    task automatic test_ties_and_width();
        int eo, es;
        for (int c = 0; c < 2; c++) begin
            clear_pulses();
            if (c == 0) frame = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
            else        frame = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 255};
            ref_argmax(frame, eo, es);
            drive_scores(0);
            @(negedge clk);
            sif.score_valid = 1'b0;
            repeat (2) @(negedge clk);
            checks++;
            if (p_cyc.size() != 1) begin errors++; $display("FAIL edge_pulse_count[%0d]: got %0d required 1", c, p_cyc.size()); end
            else begin
                checks++;
                if (p_out[0] != eo || p_score[0] != es) begin
                    errors++; $display("FAIL edge_result[%0d]: out=%0d score=%0d required %0d %0d", c, p_out[0], p_score[0], eo, es);
                end
            end
        end
    endtask

    task automatic test_gaps();
        int eo, es;
        clear_pulses();
        frame = '{3, 7, 2, 9, 1, 0, 9, 4, 5, 6};
        ref_argmax(frame, eo, es);
        chk_busy = 1'b1;
        drive_scores(40);
        chk_busy = 1'b0;
        @(negedge clk);
        sif.score_valid = 1'b0;
        checks++;
        if ({result_ready, busy} !== 2'b11) begin errors++; $display("FAIL gaps_done_busy: ready/busy=%b required 11", {result_ready, busy}); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL gaps_idle_busy: got %b required 0", busy); end
        checks++;
        if (p_cyc.size() != 1 || p_out[0] != eo || p_score[0] != es || p_cyc[0] != last_acc) begin
            errors++; $display("FAIL gaps_result: pulses=%0d out=%0d score=%0d required 1 %0d %0d",
                                p_cyc.size(), result_out, result_score, eo, es);
        end
    endtask

    task automatic test_clear();
        clear_pulses();
        frame = '{50, 50, 50, 50};
        drive_scores(0);
        @(negedge clk);
        clear = 1'b1;
        sif.score_valid = 1'b1;
        sif.score_in = 8'd200;
        @(negedge clk);
        clear = 1'b0;
        sif.score_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || p_cyc.size() != 0) begin
            errors++; $display("FAIL clear_abort: busy=%b pulses=%0d required 0 0", busy, p_cyc.size());
        end
        frame = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
        drive_scores(0);
        @(negedge clk);
        sif.score_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (p_cyc.size() != 1 || p_out[0] != 8 || p_score[0] != 9) begin
            errors++; $display("FAIL clear_result: pulses=%0d out=%0d score=%0d required 1 8 9", p_cyc.size(), result_out, result_score);
        end
    endtask

    task automatic test_clear_in_done();
        int eo, es;
        clear_pulses();
        frame.delete();
        for (int k = 0; k < NC; k++) frame.push_back($urandom_range(0, 255));
        ref_argmax(frame, eo, es);
        drive_scores(0);
        @(negedge clk);
        sif.score_valid = 1'b0;
        clear = 1'b1;
        checks++;
        if (result_ready !== 1'b1) begin errors++; $display("FAIL done_clear_pulse: got %b required 1", result_ready); end
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if (busy !== 1'b0 || sif.score_ready !== 1'b1) begin
            errors++; $display("FAIL done_clear_state: busy=%b ready=%b required 0 1", busy, sif.score_ready);
        end
        checks++;
        if (int'(result_out) != eo || int'(result_score) != es) begin
            errors++; $display("FAIL done_clear_result: out=%0d score=%0d required %0d %0d", result_out, result_score, eo, es);
        end
    endtask

    task automatic test_rst_mid_frame();
        clear_pulses();
        frame = '{50, 50, 50, 50};
        drive_scores(0);
        @(negedge clk);
        sif.score_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (sif.score_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", sif.score_ready); end
        rst = 1'b0;
        #1;
        checks++;
        if (result_out !== 4'd0 || result_score !== '0 || busy !== 1'b0 || result_ready !== 1'b0 || p_cyc.size() != 0) begin
            errors++; $display("FAIL rst_outputs: out=%0d score=%0d busy=%b pulses=%0d required all 0",
                                result_out, result_score, busy, p_cyc.size());
        end
        frame = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
        drive_scores(0);
        @(negedge clk);
        sif.score_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (p_cyc.size() != 1 || p_out[0] != 8 || p_score[0] != 9) begin
            errors++; $display("FAIL rst_result: pulses=%0d out=%0d score=%0d required 1 8 9", p_cyc.size(), result_out, result_score);
        end
    endtask

    task automatic test_back_to_back();
        int f1[$];
        int f2[$];
        int eo1, es1, eo2, es2;
        clear_pulses();
        for (int k = 0; k < NC; k++) f1.push_back($urandom_range(0, 15));
        for (int k = 0; k < NC; k++) f2.push_back($urandom_range(0, 255));
        ref_argmax(f1, eo1, es1);
        ref_argmax(f2, eo2, es2);
        frame = {f1, f2};
        drive_scores(0);
        @(negedge clk);
        sif.score_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ready_low != 1) begin errors++; $display("FAIL b2b_ready_gap: low cycles %0d required 1", ready_low); end
        checks++;
        if (p_cyc.size() != 2) begin errors++; $display("FAIL b2b_pulse_count: got %0d required 2", p_cyc.size()); end
        else begin
            checks++;
            if (p_cyc[1] - p_cyc[0] != NC + 1) begin
                errors++; $display("FAIL b2b_spacing: got %0d required %0d", p_cyc[1] - p_cyc[0], NC + 1);
            end
            checks++;
            if (p_out[0] != eo1 || p_score[0] != es1 || p_out[1] != eo2 || p_score[1] != es2) begin
                errors++; $display("FAIL b2b_results: got %0d/%0d %0d/%0d required %0d/%0d %0d/%0d",
                                    p_out[0], p_score[0], p_out[1], p_score[1], eo1, es1, eo2, es2);
            end
        end
    endtask

    task automatic test_random();
        int eo, es;
        for (int n = 0; n < 8; n++) begin
            clear_pulses();
            frame.delete();
            for (int k = 0; k < NC; k++) frame.push_back($urandom_range(0, (n % 2 == 0) ? 7 : 255));
            ref_argmax(frame, eo, es);
            drive_scores(30);
            @(negedge clk);
            sif.score_valid = 1'b0;
            repeat (2) @(negedge clk);
            checks++;
            if (p_cyc.size() != 1 || p_out[0] != eo || p_score[0] != es) begin
                errors++; $display("FAIL random_frame[%0d]: pulses=%0d out=%0d score=%0d required 1 %0d %0d",
                                    n, p_cyc.size(), result_out, result_score, eo, es);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_ties_and_width();
        test_gaps();
        test_clear();
        test_clear_in_done();
        test_rst_mid_frame();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
